// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

    localparam int unsigned OperandWidth = 14;

    // Encodings are visible on state_code and must stay fixed.
    typedef enum logic [2:0] {
        StEnterA = 3'd0,
        StEnterB = 3'd1,
        StCalc   = 3'd2,
        StShow   = 3'd3,
        StError  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpDiv = 2'd3
    } op_e;

endpackage

// File: rtl/calc_sequencer_if.sv
// Request/response handshake between the sequencer and the ALU.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic                    alu_start;
    op_e                     alu_op;
    logic [OperandWidth-1:0] alu_a;
    logic [OperandWidth-1:0] alu_b;
    logic                    alu_done;
    logic                    alu_overflow;
    logic [OperandWidth-1:0] alu_result;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_overflow, alu_result
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_overflow, alu_result
    );

endinterface

// File: rtl/calc_timeout_counter.sv
// Cycle counter bounding the wait for the ALU; saturates at Limit-1.
module calc_timeout_counter #(
    parameter int unsigned Limit = 64
) (
    input  logic clk,
    input  logic rst_ext,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(Limit - 1);

    logic [CntW-1:0] count_q;

    // Clear wins over counting; hold once the last count is reached.
    always_ff @(posedge clk or negedge rst_ext) begin
        if (!rst_ext) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign expired = (count_q == LastCount);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry, ALU launch/wait, result and error display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 64,
    parameter int unsigned MAX_VALUE   = 9999
) (
    input  logic                    clk,
    input  logic                    rst_ext,
    input  logic                    btn_next,
    input  logic                    btn_back,
    input  logic                    btn_clear,
    input  logic [1:0]              op_sel,
    input  logic [OperandWidth-1:0] number_1,
    input  logic [OperandWidth-1:0] number_2,
    calc_sequencer_if.master        alu,
    output logic                    write_number_select,
    output logic                    slider_en,
    output logic                    clear_numbers,
    output logic [OperandWidth-1:0] result,
    output logic                    result_valid,
    output logic                    error,
    output logic [2:0]              state_code
);

    state_e                  state_q, state_d;
    logic                    start_q, start_d;
    logic                    clear_q, clear_d;
    logic                    latch_ops;
    logic                    load_result;
    logic                    cnt_clear;
    logic                    cnt_expired;
    logic                    result_ok;
    logic [OperandWidth-1:0] result_q;
    logic [OperandWidth-1:0] alu_a_q, alu_b_q;
    op_e                     alu_op_q;

    calc_timeout_counter #(
        .Limit (ALU_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_ext (rst_ext),
        .clear   (cnt_clear),
        .enable  (state_q == StCalc),
        .expired (cnt_expired)
    );

    assign result_ok = !alu.alu_overflow && (32'(alu.alu_result) <= MAX_VALUE);

    // Next state plus one-shot strobes; btn_clear overrides every state.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        clear_d     = 1'b0;
        latch_ops   = 1'b0;
        load_result = 1'b0;
        cnt_clear   = 1'b0;
        if (btn_clear) begin
            state_d = StEnterA;
            clear_d = 1'b1;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    if (btn_next) state_d = StEnterB;
                end
                StEnterB: begin
                    if (btn_back) begin
                        state_d = StEnterA;
                    end else if (btn_next) begin
                        latch_ops = 1'b1;
                        // Divide by zero is rejected before the ALU ever sees it.
                        if (op_sel == OpDiv && number_2 == '0) begin
                            state_d = StError;
                        end else begin
                            state_d   = StCalc;
                            start_d   = 1'b1;
                            cnt_clear = 1'b1;
                        end
                    end
                end
                StCalc: begin
                    // A response in the timeout cycle still counts.
                    if (alu.alu_done) begin
                        if (result_ok) begin
                            load_result = 1'b1;
                            state_d     = StShow;
                        end else begin
                            state_d = StError;
                        end
                    end else if (cnt_expired) begin
                        state_d = StError;
                    end
                end
                StShow, StError: begin
                    if (btn_next) begin
                        state_d = StEnterA;
                        clear_d = 1'b1;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    // State register and registered strobes.
    always_ff @(posedge clk or negedge rst_ext) begin
        if (!rst_ext) begin
            state_q <= StEnterA;
            start_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            clear_q <= clear_d;
        end
    end

    // Operand/op snapshot taken when leaving ENTER_B forward.
    always_ff @(posedge clk or negedge rst_ext) begin
        if (!rst_ext) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OpAdd;
        end else if (latch_ops) begin
            alu_a_q  <= number_1;
            alu_b_q  <= number_2;
            alu_op_q <= op_e'(op_sel);
        end
    end

    // Result holds until the next successful calculation.
    always_ff @(posedge clk or negedge rst_ext) begin
        if (!rst_ext) begin
            result_q <= '0;
        end else if (load_result) begin
            result_q <= alu.alu_result;
        end
    end

    assign alu.alu_start        = start_q;
    assign alu.alu_op           = alu_op_q;
    assign alu.alu_a            = alu_a_q;
    assign alu.alu_b            = alu_b_q;
    assign clear_numbers        = clear_q;
    assign result               = result_q;
    assign state_code           = state_q;
    assign write_number_select  = (state_q == StEnterB);
    assign slider_en            = (state_q == StEnterA) || (state_q == StEnterB);
    assign result_valid         = (state_q == StShow);
    assign error                = (state_q == StError);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus vs. a behavioural model.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int unsigned T   = 16;
    localparam int unsigned MAX = 9999;

    logic        clk = 1'b0;
    logic        rst_ext = 1'b0;
    logic        btn_next = 1'b0, btn_back = 1'b0, btn_clear = 1'b0;
    logic [1:0]  op_sel = 2'd0;
    logic [13:0] number_1 = '0, number_2 = '0;
    logic        write_number_select, slider_en, clear_numbers, result_valid, error;
    logic [13:0] result;
    logic [2:0]  state_code;

    calc_sequencer_if alu_if ();

    calc_sequencer #(
        .ALU_TIMEOUT (T),
        .MAX_VALUE   (MAX)
    ) dut (
        .clk                 (clk),
        .rst_ext             (rst_ext),
        .btn_next            (btn_next),
        .btn_back            (btn_back),
        .btn_clear           (btn_clear),
        .op_sel              (op_sel),
        .number_1            (number_1),
        .number_2            (number_2),
        .alu                 (alu_if),
        .write_number_select (write_number_select),
        .slider_en           (slider_en),
        .clear_numbers       (clear_numbers),
        .result              (result),
        .result_valid        (result_valid),
        .error               (error),
        .state_code          (state_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW, 4 ERROR.
    int          m_state = 0;
    int          m_age = 0;
    logic [13:0] m_result = '0, m_a = '0, m_b = '0;
    int          m_op = 0;
    bit          m_start = 0, m_clear = 0;

    initial begin
        int nxt;
        forever begin
            @(posedge clk or negedge rst_ext);
            if (!rst_ext) begin
                m_state = 0; m_age = 0; m_result = '0; m_a = '0; m_b = '0;
                m_op = 0; m_start = 0; m_clear = 0;
            end else begin
                nxt = m_state;
                m_clear = 0;
                if (btn_clear) begin
                    nxt = 0;
                    m_clear = 1;
                end else if (m_state == 0) begin
                    if (btn_next) nxt = 1;
                end else if (m_state == 1) begin
                    if (btn_back) nxt = 0;
                    else if (btn_next) begin
                        m_a = number_1; m_b = number_2; m_op = int'(op_sel);
                        nxt = (op_sel == 2'd3 && number_2 == 0) ? 4 : 2;
                    end
                end else if (m_state == 2) begin
                    if (alu_if.alu_done) begin
                        if (!alu_if.alu_overflow && int'(alu_if.alu_result) <= int'(MAX)) begin
                            m_result = alu_if.alu_result;
                            nxt = 3;
                        end else nxt = 4;
                    end else if (m_age == int'(T) - 1) nxt = 4;
                end else begin
                    if (btn_next) begin
                        nxt = 0;
                        m_clear = 1;
                    end
                end
                m_start = (m_state == 1 && nxt == 2);
                if (m_state != 2 && nxt == 2) m_age = 0;
                else if (m_state == 2) m_age++;
                m_state = nxt;
            end
        end
    end

    // Compare all outputs against the model each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (alu_if.alu_start) start_cnt++;
                check("state_code", int'(state_code), m_state);
                check("slider_en", int'(slider_en), int'(m_state <= 1));
                check("write_number_select", int'(write_number_select), int'(m_state == 1));
                check("result_valid", int'(result_valid), int'(m_state == 3));
                check("error", int'(error), int'(m_state == 4));
                check("alu_start", int'(alu_if.alu_start), int'(m_start));
                check("clear_numbers", int'(clear_numbers), int'(m_clear));
                check("result", int'(result), int'(m_result));
                check("alu_a", int'(alu_if.alu_a), int'(m_a));
                check("alu_b", int'(alu_if.alu_b), int'(m_b));
                check("alu_op", int'(alu_if.alu_op), m_op);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
    endtask

    initial begin
        int sc0;
        int n;
        alu_if.alu_done = 1'b0;
        alu_if.alu_overflow = 1'b0;
        alu_if.alu_result = '0;
        repeat (3) step();
        cmp_en = 1'b1;
        check("reset_state", int'(state_code), 0);
        check("reset_result", int'(result), 0);
        check("reset_start", int'(alu_if.alu_start), 0);
        rst_ext = 1'b1;
        step();
        check("release_enter_a", int'(state_code), 0);
        check("release_slider_en", int'(slider_en), 1);

        // Basic ADD: 12 + 30 = 42
        sc0 = start_cnt;
        number_1 = 14'd12; number_2 = 14'd30; op_sel = 2'd0;
        press_next();
        check("add_enter_b", int'(state_code), 1);
        press_next();
        check("add_start", int'(alu_if.alu_start), 1);
        check("add_alu_a", int'(alu_if.alu_a), 12);
        check("add_alu_b", int'(alu_if.alu_b), 30);
        alu_if.alu_done = 1'b1; alu_if.alu_result = 14'd42;
        step();
        alu_if.alu_done = 1'b0;
        check("add_result", int'(result), 42);
        check("add_result_valid", int'(result_valid), 1);
        check("add_state_show", int'(state_code), 3);
        check("add_start_once", start_cnt - sc0, 1);

        // Divide by zero goes straight to ERROR
        press_next();
        check("show_exit_clear", int'(clear_numbers), 1);
        press_next();
        sc0 = start_cnt;
        op_sel = 2'd3; number_2 = 14'd0;
        press_next();
        check("div0_error", int'(error), 1);
        check("div0_no_start", int'(alu_if.alu_start), 0);
        step();
        check("div0_start_count", start_cnt - sc0, 0);

        // Timeout: ERROR exactly T cycles after CALC entry
        btn_clear = 1'b1;
        step();
        btn_clear = 1'b0;
        press_next();
        op_sel = 2'd0; number_2 = 14'd5;
        press_next();
        check("to_calc_entry", int'(state_code), 2);
        n = 0;
        while (state_code != 3'd4 && n < 4 * int'(T)) begin
            step();
            n++;
        end
        check("timeout_cycles", n, int'(T));

        // Clear beats next in ENTER_B; operands untouched
        press_next();
        press_next();
        number_1 = 14'd777; number_2 = 14'd888;
        btn_clear = 1'b1; btn_next = 1'b1;
        step();
        btn_clear = 1'b0; btn_next = 1'b0;
        check("clr_next_state", int'(state_code), 0);
        check("clr_next_pulse", int'(clear_numbers), 1);
        check("clr_next_alu_a", int'(alu_if.alu_a), 12);
        check("clr_next_alu_b", int'(alu_if.alu_b), 5);
        step();
        check("clr_pulse_end", int'(clear_numbers), 0);

        // Out-of-range result -> ERROR, then next returns with a clear pulse
        number_1 = 14'd100; number_2 = 14'd100;
        press_next();
        press_next();
        alu_if.alu_done = 1'b1; alu_if.alu_result = 14'd10000;
        step();
        alu_if.alu_done = 1'b0;
        check("range_error", int'(error), 1);
        press_next();
        check("range_exit_state", int'(state_code), 0);
        check("range_exit_clear", int'(clear_numbers), 1);
        step();
        check("range_clear_end", int'(clear_numbers), 0);

        // Reset mid-CALC, late alu_done ignored
        press_next();
        press_next();
        step();
        step();
        check("rst_in_calc", int'(state_code), 2);
        rst_ext = 1'b0;
        step();
        rst_ext = 1'b1;
        sc0 = start_cnt;
        alu_if.alu_done = 1'b1; alu_if.alu_result = 14'd55;
        step();
        alu_if.alu_done = 1'b0;
        check("late_done_state", int'(state_code), 0);
        check("late_done_result", int'(result), 0);
        repeat (3) step();
        check("late_no_start", start_cnt - sc0, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            btn_next  = ($urandom_range(0, 3) == 0);
            btn_back  = ($urandom_range(0, 11) == 0);
            btn_clear = ($urandom_range(0, 39) == 0);
            op_sel    = 2'($urandom_range(0, 3));
            number_1  = 14'($urandom_range(0, 16383));
            number_2  = ($urandom_range(0, 4) == 0) ? 14'd0 : 14'($urandom_range(0, 16383));
            alu_if.alu_done     = ($urandom_range(0, 6) == 0);
            alu_if.alu_overflow = ($urandom_range(0, 9) == 0);
            alu_if.alu_result   = ($urandom_range(0, 3) != 0) ? 14'($urandom_range(0, 9999))
                                                              : 14'($urandom_range(9990, 16383));
            rst_ext = ($urandom_range(0, 299) != 0);
            step();
        end
        btn_next = 1'b0; btn_back = 1'b0; btn_clear = 1'b0;
        alu_if.alu_done = 1'b0; rst_ext = 1'b1;
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL expose parameter ALU_TIMEOUT, default 64, the maximum number of cycles spent in CALC waiting for alu_done.
REQ-002 The block SHALL expose parameter MAX_VALUE, default 9999, the largest result that is displayable.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst_ext: input, 1 bit, asynchronous active-low reset.
REQ-005 Port btn_next / btn_back / btn_clear: input, 1 bit each, single-cycle debounced button pulses.
REQ-006 Port op_sel: input, 2 bits, operator choice (ADD=0, SUB=1, MUL=2, DIV=3).
REQ-007 Port number_1 / number_2: input, 14 bits each, operands from the slider increment datapath.
REQ-008 Port alu_done: input, 1 bit; alu_overflow: input, 1 bit; alu_result: input, 14 bits (ALU response).
REQ-009 Port write_number_select: output, 1 bit, operand selected for slider writes (0 = number_1).
REQ-010 Port slider_en: output, 1 bit, enables slider writes.
REQ-011 Port clear_numbers: output, 1 bit, one-cycle pulse that zeroes both operands.
REQ-012 Port alu_start: output, 1 bit, one-cycle pulse; alu_op: output, 2 bits; alu_a, alu_b: output, 14 bits each (latched operands).
REQ-013 Port result: output, 14 bits; result_valid: output, 1 bit; error: output, 1 bit; state_code: output, 3 bits (current state for the display).

Function
REQ-014 The FSM SHALL have exactly these states: ENTER_A (0), ENTER_B (1), CALC (2), SHOW (3), ERROR (4); state_code SHALL equal the state encoding.
REQ-015 ENTER_A: write_number_select=0, slider_en=1; btn_next -> ENTER_B.
REQ-016 ENTER_B: write_number_select=1, slider_en=1; btn_back -> ENTER_A; btn_next latches alu_a=number_1, alu_b=number_2, alu_op=op_sel, then -> CALC.
REQ-017 On btn_next in ENTER_B with op_sel=DIV and number_2=0, the FSM SHALL go to ERROR directly, and alu_start SHALL never assert.
REQ-018 In CALC, slider_en SHALL be 0, and alu_start SHALL pulse high for exactly the first CALC cycle.
REQ-019 The CALC timeout counter SHALL clear on entry to CALC and increment each CALC cycle.
REQ-020 On alu_done with alu_overflow=0 and alu_result<=MAX_VALUE, the FSM SHALL register result=alu_result and go to SHOW; otherwise it SHALL go to ERROR.
REQ-021 If the counter reaches ALU_TIMEOUT-1 without alu_done, the FSM SHALL go to ERROR; if alu_done and timeout coincide, alu_done SHALL win.
REQ-022 SHOW: result_valid=1 and slider_en=0; btn_next -> ENTER_A with a clear_numbers pulse; result SHALL hold until the next SHOW entry or reset.
REQ-023 ERROR: error=1, slider_en=0; btn_next or btn_clear -> ENTER_A with a clear_numbers pulse.
REQ-024 btn_clear in any state SHALL force ENTER_A and pulse clear_numbers one cycle.
REQ-025 Button priority SHALL be btn_clear > btn_back > btn_next, and at most one transition SHALL occur per cycle.
REQ-026 Buttons not listed for a state SHALL be ignored, and alu_done outside CALC SHALL be ignored.
REQ-027 Outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-028 While rst_ext=0: state=ENTER_A, result=0, alu_a=alu_b=0, alu_op=ADD, counter=0, alu_start=0, clear_numbers=0, result_valid=0, error=0.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation, and no alu_start SHALL be issued after release.
REQ-030 On the first cycle after reset release, the block SHALL be in ENTER_A with slider_en=1.

Structure
REQ-031 Package calc_pkg SHALL hold the state enum, the op enum (ADD/SUB/MUL/DIV), and the operand width constant (14).
REQ-032 The CALC wait timer SHALL be a single sub-module, calc_timeout_counter (clear, enable, expired), instantiated once.

Verification
REQ-033 Reset release, btn_next, then btn_next with number_1=12, number_2=30, op_sel=ADD, and alu_done one cycle after start with alu_result=42 -> alu_start pulses once, result=42, result_valid=1, state_code=3.
REQ-034 DIV with number_2=0 on btn_next -> error=1 on the next cycle, alu_start never high.
REQ-035 alu_done never asserted -> ERROR exactly ALU_TIMEOUT cycles after CALC entry.
REQ-036 btn_clear and btn_next in the same cycle in ENTER_B -> ENTER_A, one clear_numbers pulse, operands not latched.
REQ-037 alu_done with alu_result=10000 -> ERROR; a subsequent btn_next -> ENTER_A with clear_numbers=1 for one cycle.
REQ-038 Reset asserted two cycles into CALC, then a late alu_done after release -> ignored, state stays ENTER_A, result=0.
